// File: rtl/link_pkg.sv
// Shared definitions for the DDR link sender and receiver.
// Holds the default channel geometry, the beat-count helper and the
// error-flag record used by the receive end.
package link_pkg;

  // Default link geometry, shared with the upstream sender.
  localparam int LINK_CHANNEL_WIDTH = 8;
  localparam int LINK_NUM_CHANNELS  = 2;

  // Sticky error flags raised by the receive end.
  typedef struct packed {
    logic mismatch;
    logic overflow;
  } link_err_s;

  // Number of link beats needed to carry one core word.
  function automatic int beats_f(input int core_width, input int channel_width,
                                 input int num_channels);
    return core_width / (channel_width * num_channels);
  endfunction

endpackage

// File: rtl/link_rx_fifo.sv
// Synchronous single-write/single-read FIFO for reassembled link words.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push, push_data   - write request and word; ignored when full unless pop
//   pop               - read request; ignored when empty
//   head_data         - word at the head of the FIFO
//   full, empty       - occupancy flags
//   count             - current occupancy (0..depth)
module link_rx_fifo
  import link_pkg::*;
#(
  parameter int width_p    = 64,
  parameter int lg_depth_p = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [width_p-1:0]    push_data,
  input  logic                  pop,
  output logic [width_p-1:0]    head_data,
  output logic                  full,
  output logic                  empty,
  output logic [lg_depth_p:0]   count
);

  localparam int depth_lp = 1 << lg_depth_p;

  logic [width_p-1:0]  mem_r [depth_lp];
  logic [lg_depth_p:0] wr_ptr_r;
  logic [lg_depth_p:0] rd_ptr_r;
  logic                wr_en_s;
  logic                rd_en_s;

  // The extra MSB on each pointer separates full from empty when the
  // index bits match.
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[lg_depth_p] != rd_ptr_r[lg_depth_p]) &&
                 (wr_ptr_r[lg_depth_p-1:0] == rd_ptr_r[lg_depth_p-1:0]);
  assign count = wr_ptr_r - rd_ptr_r;

  // A write into a full FIFO is allowed only when the head leaves the
  // same cycle, reusing the freed slot.
  assign rd_en_s   = pop & ~empty;
  assign wr_en_s   = push & (~full | rd_en_s);
  assign head_data = mem_r[rd_ptr_r[lg_depth_p-1:0]];

  // Storage array and pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < depth_lp; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[lg_depth_p-1:0]] <= push_data;
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_ddr_downstream_rx.sv
// Receive end of the DDR link (single io clock domain).
// Reassembles per-channel beats into core words, buffers them in a FIFO
// drained by a valid/yumi handshake, and returns credits by toggling a
// token once per 2^lg_credit_to_token_decimation_p consumed words.
// Ports:
//   clk, rst        - io clock, synchronous active-high reset
//   io_valid_i      - per-channel beat valid (all must agree)
//   io_data_i       - beat data, channel c in bits [cw*c +: cw]
//   core_data_o     - FIFO head word
//   core_valid_o    - FIFO non-empty
//   core_yumi_i     - core consumes head this cycle
//   token_o         - credit-return token (level toggles)
//   credit_avail_o  - free FIFO entries
//   err_mismatch_o  - sticky: channels disagreed on valid
//   err_overflow_o  - sticky: word completed into a full FIFO with no pop
module link_ddr_downstream_rx
  import link_pkg::*;
#(
  parameter int core_width_p                    = 64,
  parameter int channel_width_p                 = LINK_CHANNEL_WIDTH,
  parameter int num_channels_p                  = LINK_NUM_CHANNELS,
  parameter int lg_fifo_depth_p                 = 3,
  parameter int lg_credit_to_token_decimation_p = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [num_channels_p-1:0]             io_valid_i,
  input  logic [channel_width_p*num_channels_p-1:0] io_data_i,
  output logic [core_width_p-1:0]               core_data_o,
  output logic                                  core_valid_o,
  input  logic                                  core_yumi_i,
  output logic                                  token_o,
  output logic [lg_fifo_depth_p:0]              credit_avail_o,
  output logic                                  err_mismatch_o,
  output logic                                  err_overflow_o
);

  localparam int beat_bits_lp = channel_width_p * num_channels_p;
  localparam int beats_lp     = beats_f(core_width_p, channel_width_p, num_channels_p);
  localparam int beat_w_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int depth_lp     = 1 << lg_fifo_depth_p;
  localparam logic [lg_fifo_depth_p:0] depth_cnt_lp = (lg_fifo_depth_p+1)'(depth_lp);
  localparam logic [beat_w_lp-1:0]     last_beat_lp = beat_w_lp'(beats_lp - 1);

  if (beats_lp * beat_bits_lp != core_width_p) begin : g_bad_geometry
    $fatal(1, "core_width_p must be an exact multiple of channel_width_p*num_channels_p");
  end

  logic [core_width_p-1:0]    asm_r;
  logic [beat_w_lp-1:0]       beat_cnt_r;
  logic [core_width_p-1:0]    word_s;
  logic                       all_valid_s;
  logic                       mismatch_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       push_ok_s;
  logic                       full_s;
  logic                       empty_s;
  logic [lg_fifo_depth_p:0]   count_s;
  logic [lg_fifo_depth_p:0]   count_next_s;
  logic [lg_fifo_depth_p:0]   credit_r;
  logic                       token_r;
  link_err_s                  err_r;

  assign all_valid_s  = &io_valid_i;
  assign mismatch_s   = (|io_valid_i) & ~all_valid_s;
  assign push_s       = all_valid_s && (beat_cnt_r == last_beat_lp);
  assign core_valid_o = ~empty_s;
  assign pop_s        = core_yumi_i & ~empty_s;
  assign push_ok_s    = push_s & (~full_s | pop_s);

  // Full word as it stands once the current beat is merged in; only
  // pushed on the final beat, so earlier beats come straight from asm_r.
  always_comb begin
    word_s = asm_r;
    word_s[beat_cnt_r*beat_bits_lp +: beat_bits_lp] = io_data_i;
  end

  // Occupancy after this cycle's accepted push/pop, used to register credits.
  always_comb begin
    count_next_s = count_s;
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_s + 1'b1;
      2'b01:   count_next_s = count_s - 1'b1;
      default: count_next_s = count_s;
    endcase
  end

  link_rx_fifo #(
    .width_p    (core_width_p),
    .lg_depth_p (lg_fifo_depth_p)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (word_s),
    .pop       (pop_s),
    .head_data (core_data_o),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Beat assembly: mismatched beats are dropped without advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_r      <= '0;
      beat_cnt_r <= '0;
    end else if (all_valid_s) begin
      asm_r[beat_cnt_r*beat_bits_lp +: beat_bits_lp] <= io_data_i;
      beat_cnt_r <= push_s ? '0 : beat_cnt_r + 1'b1;
    end else begin
      asm_r      <= asm_r;
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Registered free-entry count and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= depth_cnt_lp;
      err_r    <= '0;
    end else begin
      credit_r       <= depth_cnt_lp - count_next_s;
      err_r.mismatch <= err_r.mismatch | mismatch_s;
      err_r.overflow <= err_r.overflow | (push_s & full_s & ~pop_s);
    end
  end

  if (lg_credit_to_token_decimation_p == 0) begin : g_tok_every
    // Token toggles on every consumed word.
    always_ff @(posedge clk) begin
      if (rst) begin
        token_r <= 1'b0;
      end else if (pop_s) begin
        token_r <= ~token_r;
      end else begin
        token_r <= token_r;
      end
    end
  end else begin : g_tok_dec
    logic [lg_credit_to_token_decimation_p-1:0] tok_cnt_r;
    // Token toggles when the pop counter wraps back to zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        tok_cnt_r <= '0;
        token_r   <= 1'b0;
      end else if (pop_s) begin
        tok_cnt_r <= tok_cnt_r + 1'b1;
        token_r   <= (&tok_cnt_r) ? ~token_r : token_r;
      end else begin
        tok_cnt_r <= tok_cnt_r;
        token_r   <= token_r;
      end
    end
  end

  assign token_o        = token_r;
  assign credit_avail_o = credit_r;
  assign err_mismatch_o = err_r.mismatch;
  assign err_overflow_o = err_r.overflow;

endmodule

// File: tb/tb_link_ddr_downstream_rx.sv
// Scoreboard bench for link_ddr_downstream_rx with default parameters.
module tb_link_ddr_downstream_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  io_valid_i;
  logic [15:0] io_data_i;
  logic [63:0] core_data_o;
  logic        core_valid_o;
  logic        core_yumi_i;
  logic        token_o;
  logic [3:0]  credit_avail_o;
  logic        err_mismatch_o;
  logic        err_overflow_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  link_ddr_downstream_rx dut (
    .clk            (clk),
    .rst            (rst),
    .io_valid_i     (io_valid_i),
    .io_data_i      (io_data_i),
    .core_data_o    (core_data_o),
    .core_valid_o   (core_valid_o),
    .core_yumi_i    (core_yumi_i),
    .token_o        (token_o),
    .credit_avail_o (credit_avail_o),
    .err_mismatch_o (err_mismatch_o),
    .err_overflow_o (err_overflow_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && core_yumi_i) begin
      if (!core_valid_o) begin
        checks++;
        errors++;
        $display("FAIL yumi_while_empty actual=valid0 expected=valid1");
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%h expected=none", core_data_o);
      end else begin
        check("pop_data", core_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic [1:0] v, input logic y);
    io_valid_i  = v;
    io_data_i   = d;
    core_yumi_i = y;
    tick();
    io_valid_i  = 2'b00;
    io_data_i   = 16'h0000;
    core_yumi_i = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input bit expect_push, input logic yumi_last);
    if (expect_push) exp_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      beat(w[16*i +: 16], 2'b11, (i == 3) ? yumi_last : 1'b0);
    end
  endtask

  task automatic pop_word();
    core_yumi_i = 1'b1;
    tick();
    core_yumi_i = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    io_valid_i  = 2'b00;
    io_data_i   = 16'h0000;
    core_yumi_i = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("rst_valid",    64'(core_valid_o),   64'd0);
    check("rst_data",     core_data_o,         64'd0);
    check("rst_token",    64'(token_o),        64'd0);
    check("rst_credit",   64'(credit_avail_o), 64'd8);
    check("rst_mismatch", 64'(err_mismatch_o), 64'd0);
    check("rst_overflow", 64'(err_overflow_o), 64'd0);
  endtask

  function automatic logic [63:0] mk(input int n);
    return {16'hA5A5, 16'(n), 16'h5A5A ^ 16'(n), 16'(n * 3 + 1)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    io_valid_i  = 2'b00;
    io_data_i   = 16'h0000;
    core_yumi_i = 1'b0;
    tick();
    do_reset();

    // Basic word assembly and one-cycle visibility latency.
    exp_q.push_back(64'h0807060504030201);
    beat(16'h0201, 2'b11, 1'b0);
    beat(16'h0403, 2'b11, 1'b0);
    beat(16'h0605, 2'b11, 1'b0);
    check("valid_before_last", 64'(core_valid_o), 64'd0);
    beat(16'h0807, 2'b11, 1'b0);
    check("valid_after_last", 64'(core_valid_o), 64'd1);
    check("head_first", core_data_o, 64'h0807060504030201);
    check("credit_one", 64'(credit_avail_o), 64'd7);

    // Token decimation by 2.
    for (int n = 1; n <= 3; n++) send_word(mk(n), 1'b1, 1'b0);
    check("credit_four", 64'(credit_avail_o), 64'd4);
    pop_word();
    check("token_pop1", 64'(token_o), 64'd0);
    pop_word();
    check("token_pop2", 64'(token_o), 64'd1);
    pop_word();
    check("token_pop3", 64'(token_o), 64'd1);
    pop_word();
    check("token_pop4", 64'(token_o), 64'd0);
    check("credit_drained", 64'(credit_avail_o), 64'd8);

    // Overflow: 9th word into a full FIFO is dropped.
    for (int n = 10; n < 18; n++) send_word(mk(n), 1'b1, 1'b0);
    check("credit_full", 64'(credit_avail_o), 64'd0);
    check("ovf_before", 64'(err_overflow_o), 64'd0);
    send_word(mk(99), 1'b0, 1'b0);
    check("ovf_set", 64'(err_overflow_o), 64'd1);
    check("credit_full_ovf", 64'(credit_avail_o), 64'd0);
    check("head_after_ovf", core_data_o, mk(10));
    for (int n = 0; n < 8; n++) pop_word();
    check("valid_after_ovf_drain", 64'(core_valid_o), 64'd0);
    check("token_after_ovf_drain", 64'(token_o), 64'd0);

    // Push into full FIFO with a simultaneous pop.
    do_reset();
    for (int n = 20; n < 28; n++) send_word(mk(n), 1'b1, 1'b0);
    send_word(mk(28), 1'b1, 1'b1);
    check("ovf_with_pop", 64'(err_overflow_o), 64'd0);
    check("credit_full_pop", 64'(credit_avail_o), 64'd0);
    check("head_after_swap", core_data_o, mk(21));
    for (int n = 0; n < 8; n++) pop_word();
    check("valid_after_swap_drain", 64'(core_valid_o), 64'd0);
    check("token_nine_pops", 64'(token_o), 64'd0);

    // Channel valid mismatch between beats 1 and 2.
    exp_q.push_back(64'h8877665544332211);
    beat(16'h2211, 2'b11, 1'b0);
    beat(16'hDEAD, 2'b01, 1'b0);
    check("mismatch_set", 64'(err_mismatch_o), 64'd1);
    beat(16'h4433, 2'b11, 1'b0);
    beat(16'h6655, 2'b11, 1'b0);
    check("mismatch_no_early", 64'(core_valid_o), 64'd0);
    beat(16'h8877, 2'b11, 1'b0);
    check("mismatch_word_valid", 64'(core_valid_o), 64'd1);
    pop_word();
    check("token_ten_pops", 64'(token_o), 64'd1);

    // Reset in the middle of a word.
    do_reset();
    beat(16'hAAAA, 2'b11, 1'b0);
    beat(16'hBBBB, 2'b11, 1'b0);
    do_reset();
    send_word(64'h1234567890ABCDEF, 1'b1, 1'b0);
    check("fresh_valid", 64'(core_valid_o), 64'd1);
    check("fresh_head", core_data_o, 64'h1234567890ABCDEF);
    pop_word();
    check("fresh_single", 64'(core_valid_o), 64'd0);
    check("fresh_token", 64'(token_o), 64'd0);
    check("fresh_mismatch", 64'(err_mismatch_o), 64'd0);
    check("fresh_overflow", 64'(err_overflow_o), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_ddr_downstream_rx.md
Name: link_ddr_downstream_rx

Overview:
- Receive end of the upstream DDR link, modelled in the single io clock domain.
- Accepts per-channel valid/data beats from the link pins and reassembles them into core_width_p words.
- Buffers completed words in a small FIFO with a valid/yumi interface to the core.
- Returns credits to the transmitter by toggling a token line once per 2^lg_credit_to_token_decimation_p consumed words. This is the counterpart of the upstream sender's sent/finish credit counters.

Parameters:
- core_width_p, 64, core word width.
- channel_width_p, 8, bits per channel per beat.
- num_channels_p, 2, parallel link channels.
- lg_fifo_depth_p, 3, log2 of receive FIFO depth (depth 8).
- lg_credit_to_token_decimation_p, 1, log2 of words consumed per token toggle.
- Derived: beats_lp = core_width_p / (channel_width_p*num_channels_p) = 4. Must divide exactly; the design elaborates a fatal assertion otherwise.

Ports:
- clk, input, 1, io clock.
- rst, input, 1, reset; synchronous, active-high.
- io_valid_i, input, num_channels_p, per-channel beat valid.
- io_data_i, input, channel_width_p*num_channels_p, channel c occupies bits [8c+7:8c].
- core_data_o, output, core_width_p, FIFO head word.
- core_valid_o, output, 1, FIFO non-empty.
- core_yumi_i, input, 1, core consumes head this cycle; only legal when core_valid_o=1.
- token_o, output, 1, credit-return token; level toggles.
- credit_avail_o, output, lg_fifo_depth_p+1, free FIFO entries.
- err_mismatch_o, output, 1, sticky: channels disagreed on valid.
- err_overflow_o, output, 1, sticky: word completed while FIFO full with no pop.

Behaviour:
- Reset values (rst sampled high at posedge):
  - beat counter = 0; partial word discarded; FIFO emptied.
  - core_valid_o = 0; core_data_o = 0; token_o = 0; token counter = 0.
  - credit_avail_o = 2^lg_fifo_depth_p; both error flags = 0.
- Beat capture:
  - A beat is accepted when all io_valid_i bits are 1.
  - Beat k (k = beat counter) is written to assembly bits [16k+15:16k], channel 0 in the low byte.
  - The beat counter increments on each accepted beat and wraps beats_lp-1 -> 0.
- Valid mismatch: io_valid_i neither all-0 nor all-1.
  - The beat is dropped and err_mismatch_o is set.
  - The beat counter does not advance.
  - Partial word contents are retained.
- Word completion:
  - On acceptance of beat beats_lp-1, the full word is pushed into the FIFO at the same posedge.
  - core_valid_o rises the following cycle, giving 1 cycle latency from the last beat to visibility.
- FIFO:
  - Depth 2^lg_fifo_depth_p; pointers carry one extra wrap bit; full/empty distinguished by the wrap bit.
  - Pop occurs when core_yumi_i & core_valid_o. A yumi while empty is ignored; the bench asserts it never happens.
  - Push while full is legal only if a pop occurs in the same cycle; the slot is reused and occupancy is unchanged.
  - Push while full without a pop: the word is dropped, err_overflow_o is set, and FIFO contents are unaltered.
  - Simultaneous push and pop when empty cannot occur, because the push becomes visible only next cycle.
- credit_avail_o = depth - occupancy; registered, and updates the cycle after a push or pop.
- Token return:
  - Each pop increments a lg_credit_to_token_decimation_p-bit counter.
  - When the counter wraps to 0, token_o toggles on the same posedge.
  - Decimation 0 toggles on every pop.
- Error flags are cleared only by rst.
- Reset mid-word or mid-burst: all state returns to reset values and no token is emitted for discarded data.

Decomposition:
- Shared package link_pkg holds:
  - function beats_f(core_width, channel_width, num_channels);
  - localparam defaults for channel width and channel count, shared with the upstream sender;
  - typedef link_err_s {mismatch, overflow}.
- Sub-module link_rx_fifo: synchronous 1-write/1-read FIFO with full/empty/count, parameterised by width and lg depth.
- Assembler, token counter and error logic live in the top block.

Test Plan:
- Send 4 beats of io_data_i = 16'h0201, 16'h0403, 16'h0605, 16'h0807 with io_valid_i=2'b11 -> the cycle after beat 4: core_valid_o=1, core_data_o=64'h0807060504030201, credit_avail_o=7.
- Pop 2 words with decimation 1 -> token_o goes 0->1 exactly on the posedge of the 2nd yumi; a 3rd pop leaves token_o=1 and a 4th returns it to 0.
- Fill 8 words with no yumi, then complete a 9th -> err_overflow_o=1, FIFO contents unchanged, the 8 words pop in order.
- With 8 words held, complete a 9th in the same cycle as a yumi -> no error, occupancy stays 8, 9th word emerges last.
- Insert io_valid_i=2'b01 between beats 1 and 2 -> err_mismatch_o=1, and the word assembles from the 4 valid beats only.
- Assert rst after 2 beats, then send 4 fresh beats -> a single word equal to the fresh beats, token_o=0, errors clear.
